ram_ctrl: RTL
=============

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRESS_SIZE, default 9, giving the byte address width.
REQ-002 The block SHALL have parameter RAM_SIZE, default 512, giving the depth in bytes; RAM_SIZE <= 2**ADDRESS_SIZE.
REQ-003 The block SHALL have parameter WAIT_STATES, default 2, giving the clock cycles inserted before each access beat (0 allowed).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- mfa  input  1  memory function request, level-held by the requester until mfc is seen.
- rw  input  1  1 = write, 0 = read.
- byte_mode  input  2  00 word, 01 byte, 10 halfword, 11 doubleword (two beats).
- address  input  ADDRESS_SIZE  start byte address.
- data_in  input  32  write data.
- data_out  output  32  read data, registered.
- mfc  output  1  memory function complete.
- err  output  1  misalignment error; present only with RAM_ALIGN_CHECK_EN.

Function
REQ-005 Storage SHALL be RAM_SIZE bytes, big-endian: the lowest address holds the most significant byte.
REQ-006 Byte addresses SHALL wrap modulo RAM_SIZE, so address+k beyond the top rolls over to 0.
REQ-007 The FSM SHALL have the states IDLE, WAIT1, BEAT1, WAIT2 and DONE.
REQ-008 In IDLE with mfa=1, the block SHALL capture address, rw and byte_mode, load the wait counter with WAIT_STATES, and move to WAIT1.
REQ-009 In WAIT1 and WAIT2, the counter SHALL decrement each cycle; the access SHALL occur on the edge where the counter is 0.
REQ-010 Beat-1 access for non-doubleword modes SHALL be:
- write: data_in sampled on the access edge.
- byte mode: writes data_in[7:0].
- halfword mode: writes data_in[15:0].
- read, byte mode: data_out = {24'b0, byte}, zero-extended.
- read, halfword mode: data_out = {16'b0, halfword}, zero-extended.
- word mode: 4 bytes.
After the access, the FSM SHALL go to DONE with mfc=1.
REQ-011 Doubleword beat 1 SHALL access bytes address..+3, then go to BEAT1 with mfc=1 for exactly one cycle.
REQ-012 From BEAT1, the FSM SHALL reload the counter and go to WAIT2; beat 2 SHALL access bytes address+4..+7, then go to DONE with mfc=1.
REQ-013 Latency SHALL be measured from capture edge E0:
- mfc SHALL rise after edge E0+WAIT_STATES+1.
- The doubleword second mfc SHALL rise after edge E0+2*WAIT_STATES+3.
REQ-014 In DONE, mfc SHALL stay 1 and data_out SHALL hold until mfa=0; the FSM SHALL then return to IDLE, with mfc=0 on the next edge.
REQ-015 If mfa falls in WAIT1, BEAT1 or WAIT2, the FSM SHALL abort to IDLE with mfc=0; no write not yet performed SHALL occur, and completed beat-1 writes SHALL remain.
REQ-016 Changes to address, rw or byte_mode after capture SHALL be ignored; only data_in is re-sampled at beat 2.
REQ-017 A new request SHALL be accepted only from IDLE; back-to-back requests SHALL need mfa low for at least one cycle.

Reset
REQ-018 When reset_n=0, the block SHALL set the state to IDLE, mfc=0, data_out=0, err=0 and the counter=0, asynchronously.
REQ-019 Memory contents SHALL NOT be cleared by reset.
REQ-020 Reset asserted mid-access SHALL abandon the access; any write not yet performed SHALL NOT occur.

Configuration
REQ-021 With macro RAM_ALIGN_CHECK_EN defined, the block SHALL check alignment at capture:
- Misaligned means halfword with address[0]=1, word with address[1:0]!=0, or doubleword with address[2:0]!=0.
- A misaligned request SHALL skip memory access and go to DONE after WAIT_STATES+1 cycles with mfc=1 and err=1.
- err SHALL clear together with mfc.
REQ-022 Without RAM_ALIGN_CHECK_EN, the err port SHALL be absent and every address SHALL be accepted per REQ-006.

Verification
REQ-023 Word write 0xDEADBEEF to 0x010, WAIT_STATES=2 -> mfc rises 3 cycles after capture; a word read of 0x010 returns 0xDEADBEEF; a byte read of 0x011 returns 0x000000AD.
REQ-024 Doubleword write with 0x11223344 then 0x55667788 to 0x020 -> two mfc assertions; a word read of 0x024 returns 0x55667788.
REQ-025 Word write 0xA1B2C3D4 to 0x1FE, RAM_SIZE=512 -> bytes 0x1FE=A1, 0x1FF=B2, 0x000=C3, 0x001=D4.
REQ-026 mfa dropped one cycle after capture of a write of 0xFFFFFFFF to 0x030 -> mfc never rises and 0x030 is unchanged.
REQ-027 reset_n pulsed low during WAIT2 of a doubleword read -> mfc=0 and data_out=0 immediately; the next request completes normally.
REQ-028 With RAM_ALIGN_CHECK_EN, word read at 0x003 -> mfc=1 and err=1, data_out unchanged; no err on an aligned 0x004 read.

Source files
------------

// File: rtl/ram_ctrl.sv
// ram_ctrl: byte-addressed, big-endian RAM behind an mfa/mfc handshake.
// Each access beat waits WAIT_STATES cycles. Doubleword requests run two beats.
// Addresses wrap modulo RAM_SIZE.
// Optional feature: define RAM_ALIGN_CHECK_EN to add the err port.
// With it, misaligned requests complete with err=1 and do not touch memory.
module ram_ctrl #(
   parameter int ADDRESS_SIZE = 9,
   parameter int RAM_SIZE     = 512,
   parameter int WAIT_STATES  = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    mfa,
   input  logic                    rw,
   input  logic [1:0]              byte_mode,
   input  logic [ADDRESS_SIZE-1:0] address,
   input  logic [31:0]             data_in,
   output logic [31:0]             data_out,
   output logic                    mfc
`ifdef RAM_ALIGN_CHECK_EN
   ,
   output logic                    err
`endif
);

   localparam int IW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
   localparam int CW = $clog2(WAIT_STATES + 2);

   typedef enum logic [2:0] {IDLE, WAIT1, BEAT1, WAIT2, DONE} state_t;

   state_t                  state_reg, state_next;
   logic [CW-1:0]           cnt_reg;
   logic [ADDRESS_SIZE-1:0] addr_reg;
   logic                    rw_reg;
   logic [1:0]              mode_reg;
   logic                    mis_reg;
   logic [2:0]              nbytes;
   logic                    cnt_zero;
   logic                    beat_edge;
   logic                    access_en;
   logic [31:0]             beat_off;
   logic [31:0]             rd_word;
   logic [3:0]              lane_en;
   logic [IW-1:0]           lane_idx   [4];
   logic [7:0]              lane_wdata [4];

   logic [7:0]              mem [0:RAM_SIZE-1];

   assign cnt_zero  = (cnt_reg == '0);
   assign beat_edge = ((state_reg == WAIT1) || (state_reg == WAIT2)) && mfa && cnt_zero;
   assign access_en = beat_edge && !mis_reg;
   // The second doubleword beat works on the following four bytes.
   assign beat_off  = (state_reg == WAIT2) ? 32'd4 : 32'd0;

   // Number of bytes touched by one beat.
   always_comb begin
      nbytes = 3'd4;
      case (mode_reg)
         2'b01:   nbytes = 3'd1;
         2'b10:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
   end

   // Per-lane byte address with wrap, enable, and big-endian write data.
   // Lane 0 is the start address and takes the most significant active byte.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [31:0] lane_sum;
         logic [1:0]  lane_sh;
         assign lane_sum         = 32'(addr_reg) + beat_off + 32'(gi);
         assign lane_idx[gi]     = IW'(lane_sum % 32'(RAM_SIZE));
         assign lane_en[gi]      = (3'(gi) < nbytes);
         assign lane_sh          = 2'(nbytes - 3'(gi) - 3'd1);
         assign lane_wdata[gi]   = data_in[{lane_sh, 3'b000} +: 8];
      end
   endgenerate

`ifdef RAM_ALIGN_CHECK_EN
   logic mis_now;

   // Alignment rule for the incoming request.
   always_comb begin
      mis_now = 1'b0;
      case (byte_mode)
         2'b10:   mis_now = address[0];
         2'b00:   mis_now = |address[1:0];
         2'b11:   mis_now = |address[2:0];
         default: mis_now = 1'b0;
      endcase
   end

   // Latch the misalignment verdict at capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         mis_reg <= 1'b0;
      else if (state_reg == IDLE && mfa)
         mis_reg <= mis_now;
   end
`else
   assign mis_reg = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic. Dropping mfa before completion aborts to IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (mfa) state_next = WAIT1;
         WAIT1: begin
            if (!mfa)
               state_next = IDLE;
            else if (cnt_zero)
               state_next = (mode_reg == 2'b11 && !mis_reg) ? BEAT1 : DONE;
         end
         BEAT1: state_next = mfa ? WAIT2 : IDLE;
         WAIT2: begin
            if (!mfa)
               state_next = IDLE;
            else if (cnt_zero)
               state_next = DONE;
         end
         DONE:  if (!mfa) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      mfc = (state_reg == BEAT1) || (state_reg == DONE);
`ifdef RAM_ALIGN_CHECK_EN
      err = mis_reg && (state_reg == DONE);
`endif
   end

   // Capture the request. Later changes on these inputs are ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_reg <= '0;
         rw_reg   <= 1'b0;
         mode_reg <= 2'b00;
      end else if (state_reg == IDLE && mfa) begin
         addr_reg <= address;
         rw_reg   <= rw;
         mode_reg <= byte_mode;
      end
   end

   // Wait-state counter: loaded before each beat, counts down to the access edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_reg <= '0;
      else if ((state_reg == IDLE && mfa) || state_reg == BEAT1)
         cnt_reg <= CW'(WAIT_STATES);
      else if ((state_reg == WAIT1 || state_reg == WAIT2) && !cnt_zero)
         cnt_reg <= cnt_reg - 1'b1;
   end

   // Assemble the big-endian read word, zero-extending byte and halfword reads.
   always_comb begin
      rd_word = {mem[lane_idx[0]], mem[lane_idx[1]], mem[lane_idx[2]], mem[lane_idx[3]]};
      case (mode_reg)
         2'b01:   rd_word = {24'b0, mem[lane_idx[0]]};
         2'b10:   rd_word = {16'b0, mem[lane_idx[0]], mem[lane_idx[1]]};
         default: ;
      endcase
   end

   // Registered read data. It holds until the next read beat or a reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         data_out <= '0;
      else if (access_en && !rw_reg)
         data_out <= rd_word;
   end

   // Byte-lane memory writes. This array is never reset.
   always_ff @(posedge clk) begin
      if (access_en && rw_reg) begin
         for (int k = 0; k < 4; k++) begin
            if (lane_en[k])
               mem[lane_idx[k]] <= lane_wdata[k];
         end
      end
   end

endmodule
